// File: rtl/cache_fsm_l2a_if.sv
// L1-facing request/response lines and next-level memory port of the L2 controller.
interface cache_fsm_l2a_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LINE_WIDTH    = 128
);
  logic [ADDRESS_WIDTH-1:0] l2_address;
  logic                     read_from_L2a_request;
  logic                     write_to_L2a_request;
  logic                     write_back_to_L2a_request;
  logic [DATA_WIDTH-1:0]    write_word_data;
  logic [LINE_WIDTH-1:0]    write_back_line_data;
  logic                     L2_ready;
  logic [LINE_WIDTH-1:0]    L2_read_line;
  logic                     write_to_L2_verified;
  logic                     write_back_to_L2_verified;
  logic                     L2_cache_hit;
  logic                     L2_cache_miss;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_read_request;
  logic                     mem_write_request;
  logic [LINE_WIDTH-1:0]    mem_write_data;
  logic [LINE_WIDTH-1:0]    mem_read_data;
  logic                     mem_ready;

  modport slave (
    input  l2_address, read_from_L2a_request, write_to_L2a_request, write_back_to_L2a_request,
           write_word_data, write_back_line_data, mem_read_data, mem_ready,
    output L2_ready, L2_read_line, write_to_L2_verified, write_back_to_L2_verified,
           L2_cache_hit, L2_cache_miss, mem_address, mem_read_request, mem_write_request,
           mem_write_data
  );

  modport master (
    output l2_address, read_from_L2a_request, write_to_L2a_request, write_back_to_L2a_request,
           write_word_data, write_back_line_data, mem_read_data, mem_ready,
    input  L2_ready, L2_read_line, write_to_L2_verified, write_back_to_L2_verified,
           L2_cache_hit, L2_cache_miss, mem_address, mem_read_request, mem_write_request,
           mem_write_data
  );
endinterface

// File: rtl/cache_fsm_l2a.sv
// Direct-mapped write-back L2 controller: serves L1 fills, word writes and line write-backs,
// evicting/fetching whole lines through a level-hold / ready-pulse next-level port.
module cache_fsm_l2a #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int NUM_SETS      = 16
) (
  input logic             clk,
  input logic             reset,
  cache_fsm_l2a_if.slave  bus
);
  localparam int WORDS = LINE_WIDTH / DATA_WIDTH;
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_LO = OFF_W + 2 + IDX_W;
  localparam int TAG_W = ADDRESS_WIDTH - 2 - TAG_LO;
  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = {{(ADDRESS_WIDTH-OFF_W-2){1'b1}}, {(OFF_W+2){1'b0}}};

  typedef enum logic [2:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE, RESPOND} state_t;
  typedef enum logic [1:0] {REQ_RD, REQ_WR, REQ_WB} req_t;

  state_t state, state_nx;
  req_t   req_kind;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_word;
  logic [LINE_WIDTH-1:0]    req_line;

  logic [NUM_SETS-1:0]      valid, dirty;
  logic [TAG_W-1:0]         tag_mem  [NUM_SETS];
  logic [LINE_WIDTH-1:0]    data_mem [NUM_SETS];
  logic [ADDRESS_WIDTH-1:0] addr_mem [NUM_SETS];

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [TAG_W-1:0] tag;
  logic             hit, victim_dirty, any_req;
  logic [LINE_WIDTH-1:0] merged;

  assign idx = req_addr[OFF_W+2 +: IDX_W];
  assign off = req_addr[2 +: OFF_W];
  // processor-ID bits sit above the tag and never take part in the lookup
  assign tag = req_addr[ADDRESS_WIDTH-3:TAG_LO];
  assign hit = valid[idx] && (tag_mem[idx] == tag);
  assign victim_dirty = valid[idx] && dirty[idx];
  assign any_req = bus.read_from_L2a_request | bus.write_to_L2a_request | bus.write_back_to_L2a_request;

  // word merge onto either the resident line (hit) or the incoming fill (allocate)
  always_comb begin
    merged = (state == ALLOCATE) ? bus.mem_read_data : data_mem[idx];
    merged[off*DATA_WIDTH +: DATA_WIDTH] = req_word;
  end

  always_comb begin
    state_nx                      = state;
    bus.L2_ready                  = 1'b0;
    bus.L2_read_line              = '0;
    bus.write_to_L2_verified      = 1'b0;
    bus.write_back_to_L2_verified = 1'b0;
    bus.L2_cache_hit              = 1'b0;
    bus.L2_cache_miss             = 1'b0;
    bus.mem_address               = '0;
    bus.mem_read_request          = 1'b0;
    bus.mem_write_request         = 1'b0;
    bus.mem_write_data            = '0;
    case (state)
      IDLE: if (any_req) state_nx = COMPARE;
      COMPARE: begin
        bus.L2_cache_hit  = hit;
        bus.L2_cache_miss = !hit;
        if (hit)                   state_nx = RESPOND;
        else if (victim_dirty)     state_nx = WRITE_BACK;
        else if (req_kind == REQ_WB) state_nx = RESPOND;
        else                       state_nx = ALLOCATE;
      end
      WRITE_BACK: begin
        bus.mem_address       = addr_mem[idx] & LINE_MASK;
        bus.mem_write_data    = data_mem[idx];
        bus.mem_write_request = 1'b1;
        if (bus.mem_ready) state_nx = (req_kind == REQ_WB) ? RESPOND : ALLOCATE;
      end
      ALLOCATE: begin
        bus.mem_address      = req_addr & LINE_MASK;
        bus.mem_read_request = 1'b1;
        if (bus.mem_ready) state_nx = RESPOND;
      end
      RESPOND: begin
        case (req_kind)
          REQ_RD: begin
            bus.L2_ready     = 1'b1;
            bus.L2_read_line = data_mem[idx];
          end
          REQ_WR:  bus.write_to_L2_verified      = 1'b1;
          default: bus.write_back_to_L2_verified = 1'b1;
        endcase
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_kind <= REQ_RD;
      req_addr <= '0;
      req_word <= '0;
      req_line <= '0;
      valid    <= '0;
      dirty    <= '0;
      for (int i = 0; i < NUM_SETS; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (any_req) begin
          req_addr <= bus.l2_address;
          req_word <= bus.write_word_data;
          req_line <= bus.write_back_line_data;
          if (bus.write_back_to_L2a_request) req_kind <= REQ_WB;
          else if (bus.write_to_L2a_request) req_kind <= REQ_WR;
          else                               req_kind <= REQ_RD;
        end
        COMPARE: begin
          if (hit && req_kind != REQ_RD) begin
            data_mem[idx] <= (req_kind == REQ_WR) ? merged : req_line;
            addr_mem[idx] <= req_addr;
            dirty[idx]    <= 1'b1;
          end else if (!hit && !victim_dirty && req_kind == REQ_WB) begin
            valid[idx]    <= 1'b1;
            dirty[idx]    <= 1'b1;
            tag_mem[idx]  <= tag;
            addr_mem[idx] <= req_addr;
            data_mem[idx] <= req_line;
          end
        end
        WRITE_BACK: if (bus.mem_ready) begin
          if (req_kind == REQ_WB) begin
            tag_mem[idx]  <= tag;
            addr_mem[idx] <= req_addr;
            data_mem[idx] <= req_line;
            dirty[idx]    <= 1'b1;
          end else begin
            dirty[idx]    <= 1'b0;
          end
        end
        ALLOCATE: if (bus.mem_ready) begin
          valid[idx]    <= 1'b1;
          dirty[idx]    <= (req_kind == REQ_WR);
          tag_mem[idx]  <= tag;
          addr_mem[idx] <= req_addr;
          data_mem[idx] <= (req_kind == REQ_WR) ? merged : bus.mem_read_data;
        end
        default: ;
      endcase
    end
  end
endmodule
